// File: rtl/pipe_stage_if.sv
// rtl/pipe_stage_if.sv - handshake bundle between a pipe_stage and its upstream/downstream neighbours.
interface pipe_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occ_o;

    modport master (
        output flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, occ_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, occ_o
    );
endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - registered valid/ready pipeline stage with flush.
// PIPE_STAGE_SKID_EN adds a skid entry and a fully registered in_ready_o.
module pipe_stage #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    pipe_stage_if.slave  bus
);
    logic in_xfer;
    logic out_xfer;
    logic valid_q;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;

    assign in_xfer  = bus.in_valid_i && ready_q && !bus.flush_i;
    assign out_xfer = valid_q && bus.out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_d = ONE;
                    main_d  = bus.in_data_i;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = bus.in_data_i;
                    end else if (in_xfer) begin
                        state_d = TWO;
                        skid_d  = bus.in_data_i;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                TWO: if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = NOP_VALUE;
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // valid and ready are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != TWO);
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = main_q;
    assign bus.occ_o       = state_q;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready;

    // Ready looks through to downstream so a full stage still streams every cycle.
    assign ready    = !valid_q || bus.out_ready_i;
    assign in_xfer  = bus.in_valid_i && ready && !bus.flush_i;
    assign out_xfer = valid_q && bus.out_ready_i;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
            data_d  = NOP_VALUE;
        end else if (in_xfer) begin
            state_d = FULL;
            data_d  = bus.in_data_i;
        end else if (out_xfer) begin
            state_d = EMPTY;
            data_d  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= NOP_VALUE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= (state_d == FULL);
        end
    end

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = valid_q;
    assign bus.out_data_o  = data_q;
    assign bus.occ_o       = {1'b0, (state_q == FULL)};
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed and random checks of pipe_stage against a queue model.
module tb_pipe_stage;
    localparam int          W   = 32;
    localparam logic [W-1:0] NOP = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_if #(.DATA_W(W)) bus ();
    pipe_stage #(.DATA_W(W), .NOP_VALUE(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capacity of the stage and when it may accept, stated from its contract.
    function automatic logic model_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ordy;
`endif
    endfunction

    task automatic check_model(input string tag, input logic ordy);
        chk({tag, ":valid"}, W'(bus.out_valid_o), W'(q.size() != 0));
        chk({tag, ":data"},  bus.out_data_o, (q.size() != 0) ? q[0] : NOP);
        chk({tag, ":occ"},   W'(bus.occ_o), W'(q.size()));
        chk({tag, ":ready"}, W'(bus.in_ready_o), W'(model_ready(ordy)));
    endtask

    task automatic step(input string tag, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
        logic in_acc, out_acc;
        bus.flush_i     = f;
        bus.in_valid_i  = iv;
        bus.in_data_i   = d;
        bus.out_ready_i = ordy;
        #1;
        check_model(tag, ordy);
        in_acc  = iv && model_ready(ordy) && !f;
        out_acc = (q.size() != 0) && ordy;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (out_acc) void'(q.pop_front());
            if (in_acc) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step("drain", 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        bus.flush_i = 0; bus.in_valid_i = 0; bus.in_data_i = '0; bus.out_ready_i = 0;
        #2;
        chk("rst_valid", W'(bus.out_valid_o), W'(0));
        chk("rst_data",  bus.out_data_o, NOP);
        chk("rst_occ",   W'(bus.occ_o), W'(0));
        chk("rst_ready", W'(bus.in_ready_o), W'(1));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // streaming 1..4
        for (int i = 1; i <= 4; i++) step("stream", 1'b0, 1'b1, W'(i), 1'b1);
        drain();

        // async reset with one entry held
        step("load", 1'b0, 1'b1, 32'h55, 1'b0);
        chk("pre_rst_occ", W'(bus.occ_o), W'(1));
        bus.in_valid_i = 0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", W'(bus.out_valid_o), W'(0));
        chk("mid_rst_data",  bus.out_data_o, NOP);
        chk("mid_rst_ready", W'(bus.in_ready_o), W'(1));
        chk("mid_rst_occ",   W'(bus.occ_o), W'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b0, 1'b1, 32'h66, 1'b1);
        drain();

`ifdef PIPE_STAGE_SKID_EN
        step("bp_a", 1'b0, 1'b1, 32'hA, 1'b0);
        step("bp_b", 1'b0, 1'b1, 32'hB, 1'b0);
        chk("bp_occ2",   W'(bus.occ_o), W'(2));
        chk("bp_ready0", W'(bus.in_ready_o), W'(0));
        step("bp_outa", 1'b0, 1'b1, 32'hEE, 1'b1);
        chk("bp_ready1", W'(bus.in_ready_o), W'(1));
        chk("bp_datab",  bus.out_data_o, 32'hB);
        step("bp_outb", 1'b0, 1'b0, '0, 1'b1);
`else
        step("bp_c", 1'b0, 1'b1, 32'hC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b0, 1'b1, $urandom, 1'b0);
            chk("bp_hold_c", bus.out_data_o, 32'hC);
        end
`endif
        drain();

        // flush with a full stage and a same-cycle valid input
        step("fill1", 1'b0, 1'b1, 32'h11, 1'b0);
        step("fill2", 1'b0, 1'b1, 32'h22, 1'b0);
        step("flush", 1'b1, 1'b1, 32'hD, 1'($urandom));
        chk("fl_occ",   W'(bus.occ_o), W'(0));
        chk("fl_valid", W'(bus.out_valid_o), W'(0));
        chk("fl_data",  bus.out_data_o, NOP);
        drain();

        for (int i = 0; i < 10000; i++)
            step("rand", 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
                 $urandom, 1'($urandom_range(0, 2) != 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
